tehb_fifo: RTL and testbench

- Multi-slot transparent elastic buffer. It is the ready-path counterpart of the opaque valid/data-path buffer chain.
- Sits between two handshake units and registers the backpressure path.
- ins_ready depends only on internal state, never combinationally on outs_ready.
- When empty, data passes through with zero latency. Up to NUM_SLOTS tokens are absorbed while the consumer stalls.

---
 rtl/tehb_fifo_if.sv | 22 ++
 rtl/tehb_fifo.sv | 68 ++++++
 tb/tb_tehb_fifo.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/tehb_fifo_if.sv
// Handshake bundle for tehb_fifo: producer-side channel (ins) and consumer-side channel (outs).
// The buffer takes the slave view; whatever drives it takes the master view.
interface tehb_fifo_if #(
    parameter int unsigned DATA_TYPE = 32
);
    logic [DATA_TYPE-1:0] ins;
    logic                 ins_valid;
    logic                 ins_ready;
    logic [DATA_TYPE-1:0] outs;
    logic                 outs_valid;
    logic                 outs_ready;

    modport master (
        output ins, ins_valid, outs_ready,
        input  ins_ready, outs, outs_valid
    );

    modport slave (
        input  ins, ins_valid, outs_ready,
        output ins_ready, outs, outs_valid
    );
endinterface

// File: rtl/tehb_fifo.sv
// Multi-slot transparent elastic buffer: registers the ready path, passes data through
// combinationally when empty and absorbs up to NUM_SLOTS tokens while the consumer stalls.
module tehb_fifo #(
    parameter int unsigned DATA_TYPE = 32,
    parameter int unsigned NUM_SLOTS = 4
) (
    input logic          clk,
    input logic          rst,
    tehb_fifo_if.slave   io
);
    localparam int unsigned PTR_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int unsigned CNT_W = $clog2(NUM_SLOTS + 1);

    logic [DATA_TYPE-1:0] mem [NUM_SLOTS];
    logic [PTR_W-1:0]     head;
    logic [PTR_W-1:0]     tail;
    logic [CNT_W-1:0]     count;

    logic empty;
    logic full;
    logic accept;
    logic bypass;
    logic wr;
    logic rd;

    always_comb begin
        empty  = (count == '0);
        full   = (count == CNT_W'(NUM_SLOTS));
        accept = io.ins_valid & ~full;
        bypass = empty & accept & io.outs_ready;
        wr     = accept & ~bypass;
        rd     = ~empty & io.outs_ready;
    end

    // ins_ready comes from registered occupancy only, so no outs_ready -> ins_ready path exists.
    always_comb begin
        io.ins_ready  = ~full;
        io.outs_valid = io.ins_valid | ~empty;
        io.outs       = empty ? io.ins : mem[head];
    end

    always_ff @(posedge clk) begin
        if (wr) begin
            mem[tail] <= io.ins;
        end
    end

    // Explicit wrap at NUM_SLOTS-1 keeps non-power-of-two depths correct.
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (wr) begin
                tail <= (tail == PTR_W'(NUM_SLOTS - 1)) ? '0 : tail + 1'b1;
            end
            if (rd) begin
                head <= (head == PTR_W'(NUM_SLOTS - 1)) ? '0 : head + 1'b1;
            end
            case ({wr, rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_tehb_fifo.sv
// Directed bench for tehb_fifo: a 4-slot/32-bit and a 3-slot/8-bit instance checked
// against a token-queue scoreboard of the buffer's contents.
module tb_tehb_fifo;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    tehb_fifo_if #(.DATA_TYPE(32)) if4 ();
    tehb_fifo_if #(.DATA_TYPE(8))  if3 ();

    tehb_fifo #(.DATA_TYPE(32), .NUM_SLOTS(4)) u4 (.clk(clk), .rst(rst), .io(if4.slave));
    tehb_fifo #(.DATA_TYPE(8),  .NUM_SLOTS(3)) u3 (.clk(clk), .rst(rst), .io(if3.slave));

    logic [31:0] q4[$];
    logic [7:0]  q3[$];
    int          n_assert;
    int          n_fail;
    bit          chk_en;
    bit          watch7;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] e;
        chk({tag, "/u4_ready"}, 32'(if4.ins_ready), 32'(q4.size() < 4));
        chk({tag, "/u4_valid"}, 32'(if4.outs_valid), 32'(if4.ins_valid || q4.size() != 0));
        if (if4.ins_valid || q4.size() != 0) begin
            e = (q4.size() != 0) ? q4[0] : if4.ins;
            chk({tag, "/u4_data"}, if4.outs, e);
        end
        chk({tag, "/u3_ready"}, 32'(if3.ins_ready), 32'(q3.size() < 3));
        chk({tag, "/u3_valid"}, 32'(if3.outs_valid), 32'(if3.ins_valid || q3.size() != 0));
        if (if3.ins_valid || q3.size() != 0) begin
            e = 32'((q3.size() != 0) ? q3[0] : if3.ins);
            chk({tag, "/u3_data"}, 32'(if3.outs), e);
        end
        if (watch7) begin
            chk({tag, "/no_stale"}, 32'(if4.outs_valid && if4.outs == 32'h7), 32'h0);
        end
    endtask

    // Scoreboard update at the active edge, using the inputs the DUT samples there.
    task automatic model_step();
        bit acc, byp, rd;
        if (rst) begin
            q4.delete();
            q3.delete();
            return;
        end
        acc = if4.ins_valid && (q4.size() < 4);
        rd  = (q4.size() != 0) && if4.outs_ready;
        byp = (q4.size() == 0) && acc && if4.outs_ready;
        if (rd) void'(q4.pop_front());
        if (acc && !byp) q4.push_back(if4.ins);
        acc = if3.ins_valid && (q3.size() < 3);
        rd  = (q3.size() != 0) && if3.outs_ready;
        byp = (q3.size() == 0) && acc && if3.outs_ready;
        if (rd) void'(q3.pop_front());
        if (acc && !byp) q3.push_back(if3.ins);
    endtask

    task automatic cycle(input string tag);
        @(negedge clk);
        if (chk_en) check_all(tag);
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive4(input logic v, input logic [31:0] d, input logic r);
        if4.ins_valid  = v;
        if4.ins        = d;
        if4.outs_ready = r;
    endtask

    task automatic drive3(input logic v, input logic [7:0] d, input logic r);
        if3.ins_valid  = v;
        if3.ins        = d;
        if3.outs_ready = r;
    endtask

    // Flip outs_ready within one cycle; ins_ready must not move.
    task automatic iso(input logic exp);
        logic r0, r1;
        if4.outs_ready = 1'b0;
        #1 r0 = if4.ins_ready;
        if4.outs_ready = 1'b1;
        #1 r1 = if4.ins_ready;
        chk("iso_same", 32'(r1), 32'(r0));
        chk("iso_level", 32'(r0), 32'(exp));
        if4.outs_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] d3;
        bit         acc;
        bit         pat[18];

        n_assert = 0;
        n_fail   = 0;
        chk_en   = 1'b0;
        watch7   = 1'b0;
        pat      = '{0, 0, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1};

        rst = 1'b1;
        drive4(1'b0, 32'h0, 1'b0);
        drive3(1'b0, 8'h0, 1'b0);
        cycle("rst0");
        cycle("rst1");
        rst    = 1'b0;
        chk_en = 1'b1;
        cycle("reset_state");

        drive4(1'b1, 32'hA5, 1'b1);
        drive3(1'b1, 8'hA5, 1'b1);
        cycle("bypass");
        drive4(1'b0, 32'h0, 1'b1);
        drive3(1'b0, 8'h0, 1'b1);
        cycle("post_bypass");

        drive3(1'b0, 8'h0, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            drive4(1'b1, 32'(i), 1'b0);
            cycle("fill");
        end
        drive4(1'b0, 32'h0, 1'b0);
        cycle("full_hold");
        for (int i = 0; i < 5; i++) begin
            drive4(1'b0, 32'h0, 1'b1);
            cycle("drain");
        end

        drive4(1'b0, 32'h0, 1'b0);
        d3 = 8'h10;
        for (int i = 0; i < 18; i++) begin
            acc = (q3.size() < 3);
            drive3(1'b1, d3, pat[i]);
            cycle("wrap");
            if (acc) d3++;
        end
        for (int i = 0; i < 4; i++) begin
            drive3(1'b0, 8'h0, 1'b1);
            cycle("wrap_drain");
        end
        drive3(1'b0, 8'h0, 1'b0);

        drive4(1'b1, 32'h21, 1'b0);
        cycle("iso_fill");
        drive4(1'b1, 32'h22, 1'b0);
        cycle("iso_fill");
        drive4(1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            iso(1'b1);
            cycle("iso_cnt2");
        end
        drive4(1'b1, 32'h23, 1'b0);
        cycle("iso_fill");
        drive4(1'b1, 32'h24, 1'b0);
        cycle("iso_fill");
        drive4(1'b0, 32'h0, 1'b0);
        iso(1'b0);
        cycle("iso_full");
        for (int i = 0; i < 5; i++) begin
            drive4(1'b0, 32'h0, 1'b1);
            cycle("iso_drain");
        end

        for (int i = 5; i <= 7; i++) begin
            drive4(1'b1, 32'(i), 1'b0);
            cycle("pre_rst");
        end
        drive4(1'b0, 32'h0, 1'b0);
        rst = 1'b1;
        cycle("mid_rst");
        rst    = 1'b0;
        watch7 = 1'b1;
        cycle("post_rst");
        drive4(1'b1, 32'h9, 1'b0);
        cycle("post_rst_valid");
        for (int i = 0; i < 4; i++) begin
            drive4(1'b0, 32'h0, 1'b1);
            cycle("post_rst_drain");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
